// File: rtl/bf_row_ctrl_if.sv
// Request/response bundle for the bit-filter row controller: insert and
// query handshakes plus the unbuffered query response.
interface bf_row_ctrl_if #(
    parameter int ADDR_W = 12
) ();
    logic              ins_valid;
    logic              ins_ready;
    logic [ADDR_W-1:0] ins_addr;
    logic              qry_valid;
    logic              qry_ready;
    logic [ADDR_W-1:0] qry_addr;
    logic              rsp_valid;
    logic              rsp_hit;

    modport master (
        output ins_valid, ins_addr, qry_valid, qry_addr,
        input  ins_ready, qry_ready, rsp_valid, rsp_hit
    );

    modport slave (
        input  ins_valid, ins_addr, qry_valid, qry_addr,
        output ins_ready, qry_ready, rsp_valid, rsp_hit
    );
endinterface

// File: rtl/bf_row_ctrl.sv
// Bit-filter row controller: sets and tests single bits in an external
// dual-port bit RAM and sweeps the whole RAM to zero on request.
module bf_row_ctrl #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    bf_row_ctrl_if.slave      bus,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [15:0]       hit_cnt,
    output logic [ADDR_W-1:0] ram_address_a,
    output logic              ram_data_a,
    output logic              ram_wren_a,
    output logic [ADDR_W-1:0] ram_address_b,
    output logic              ram_data_b,
    output logic              ram_wren_b,
    input  logic              ram_q_b
);

    localparam int HALF_W = ADDR_W - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HALF_W-1:0]   clr_cnt;
    logic [HALF_W-1:0]   clr_cnt_next;
    logic                clr_last;
    logic                accepting;
    logic                ins_acc;
    logic                qry_acc;
    logic                fwd;
    logic [RD_LAT-1:0]   pipe_v;
    logic [RD_LAT-1:0]   pipe_f;
    logic                done_q;
    logic                hit_now;

    // Handshakes are gated by reset_n so nothing reaches the RAM while reset is held.
    assign accepting     = (state == IDLE) && reset_n;
    assign bus.ins_ready = accepting;
    assign bus.qry_ready = accepting;
    assign ins_acc       = bus.ins_valid && accepting;
    assign qry_acc       = bus.qry_valid && accepting;
    assign fwd           = ins_acc && qry_acc && (bus.ins_addr == bus.qry_addr);
    assign clr_last      = (clr_cnt == {HALF_W{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // During CLEAR the two ports sweep the lower and upper halves in parallel.
    always_comb begin
        ram_address_a = '0;
        ram_data_a    = 1'b0;
        ram_wren_a    = 1'b0;
        ram_address_b = '0;
        ram_data_b    = 1'b0;
        ram_wren_b    = 1'b0;
        if ((state == CLEAR) && reset_n) begin
            ram_address_a = {1'b0, clr_cnt};
            ram_wren_a    = 1'b1;
            ram_address_b = {1'b1, clr_cnt};
            ram_wren_b    = 1'b1;
        end else begin
            if (ins_acc) begin
                ram_address_a = bus.ins_addr;
                ram_data_a    = 1'b1;
                ram_wren_a    = 1'b1;
            end
            if (qry_acc) begin
                ram_address_b = bus.qry_addr;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == CLEAR) && clr_last;
        end
    end

    assign clr_busy = (state == CLEAR);
    assign clr_done = done_q;

    // The forward flag covers a same-cycle insert the RAM read cannot see yet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            pipe_f <= '0;
        end else begin
            pipe_v[0] <= qry_acc;
            pipe_f[0] <= fwd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_f[i] <= pipe_f[i-1];
            end
        end
    end

    assign hit_now       = pipe_v[RD_LAT-1] && (ram_q_b || pipe_f[RD_LAT-1]);
    assign bus.rsp_valid = pipe_v[RD_LAT-1];
    assign bus.rsp_hit   = hit_now;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt <= '0;
        end else if (hit_now && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bf_row_ctrl.sv
// Directed bench for bf_row_ctrl with a behavioural 4096x1 RAM whose
// contents start all ones so that every clear is observable.
module tb_bf_row_ctrl;

    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4096;

    typedef struct {
        logic        iv;
        logic [11:0] ia;
        logic        qv;
        logic [11:0] qa;
        logic        erv;
        logic        ehit;
        logic [15:0] ecnt;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              clr_done;
    logic [15:0]       hit_cnt;
    logic [ADDR_W-1:0] ram_address_a;
    logic              ram_data_a;
    logic              ram_wren_a;
    logic [ADDR_W-1:0] ram_address_b;
    logic              ram_data_b;
    logic              ram_wren_b;
    logic              ram_q_b;

    logic              mem [DEPTH];
    logic              rd_pipe [RD_LAT];

    int                n_checks = 0;
    int                n_fail = 0;
    vec_t              vecs[$];

    bf_row_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    bf_row_ctrl #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .hit_cnt       (hit_cnt),
        .ram_address_a (ram_address_a),
        .ram_data_a    (ram_data_a),
        .ram_wren_a    (ram_wren_a),
        .ram_address_b (ram_address_b),
        .ram_data_b    (ram_data_b),
        .ram_wren_b    (ram_wren_b),
        .ram_q_b       (ram_q_b)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'b1;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 1'b0;
    end

    // Read-old-data RAM model with an RD_LAT-deep output pipeline on port B.
    always @(posedge clock) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
        rd_pipe[0] <= mem[ram_address_b];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_q_b = rd_pipe[RD_LAT-1];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [11:0] ia, input logic qv, input logic [11:0] qa,
                           input logic erv, input logic ehit, input logic [15:0] ecnt);
        vec_t v;
        v.iv = iv; v.ia = ia; v.qv = qv; v.qa = qa;
        v.erv = erv; v.ehit = ehit; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge clock);
        #1;
        bus.ins_valid = v.iv;
        bus.ins_addr  = v.ia;
        bus.qry_valid = v.qv;
        bus.qry_addr  = v.qa;
        @(negedge clock);
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("%s[%0d] ins_ready", tag, i), bus.ins_ready, 1);
            check_output($sformatf("%s[%0d] rsp_valid", tag, i), bus.rsp_valid, vecs[i].erv);
            check_output($sformatf("%s[%0d] rsp_hit", tag, i), bus.rsp_hit, vecs[i].ehit);
            check_output($sformatf("%s[%0d] hit_cnt", tag, i), hit_cnt, vecs[i].ecnt);
            check_output($sformatf("%s[%0d] wren_a", tag, i), ram_wren_a, vecs[i].iv);
            if (vecs[i].iv) begin
                check_output($sformatf("%s[%0d] addr_a", tag, i), ram_address_a, vecs[i].ia);
                check_output($sformatf("%s[%0d] data_a", tag, i), ram_data_a, 1);
            end
            if (vecs[i].qv) begin
                check_output($sformatf("%s[%0d] addr_b", tag, i), ram_address_b, vecs[i].qa);
                check_output($sformatf("%s[%0d] wren_b", tag, i), ram_wren_b, 0);
            end
        end
        @(posedge clock);
        #1;
        bus.ins_valid = 1'b0;
        bus.qry_valid = 1'b0;
    endtask

    task automatic start_clear(input logic iv, input logic [11:0] ia, input logic qv, input logic [11:0] qa);
        @(posedge clock);
        #1;
        clr_start     = 1'b1;
        bus.ins_valid = iv;
        bus.ins_addr  = ia;
        bus.qry_valid = qv;
        bus.qry_addr  = qa;
        @(negedge clock);
        check_output("clr_start cycle ins_ready", bus.ins_ready, 1);
        check_output("clr_start cycle wren_a", ram_wren_a, iv);
        @(posedge clock);
        #1;
        clr_start     = 1'b0;
        bus.ins_valid = 1'b0;
        bus.qry_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_clear(output int busy, output int ready_hi, output int rsp_idx,
                              output logic rsp_h, output logic done_seen);
        logic [11:0] last_a;
        logic [11:0] last_b;
        busy = 0; ready_hi = 0; rsp_idx = -1; rsp_h = 1'b0; done_seen = 1'b0;
        last_a = '0; last_b = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 0) begin
                check_output("clear first addr_a", ram_address_a, 12'h000);
                check_output("clear first addr_b", ram_address_b, 12'h800);
                check_output("clear first wren", {ram_wren_a, ram_wren_b, ram_data_a, ram_data_b}, 4'b1100);
            end
            if (clr_busy) begin
                busy++;
                if (bus.ins_ready || bus.qry_ready) ready_hi++;
                last_a = ram_address_a;
                last_b = ram_address_b;
            end
            if (bus.rsp_valid) begin
                rsp_idx = cyc;
                rsp_h   = bus.rsp_hit;
            end
            if (clr_done) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clock);
            @(negedge clock);
        end
        check_output("clear done seen", done_seen, 1);
        check_output("clear last addr_a", last_a, 12'h7FF);
        check_output("clear last addr_b", last_b, 12'hFFF);
        check_output("clr_done busy low", clr_busy, 0);
        check_output("clr_done ready high", bus.qry_ready, 1);
        @(posedge clock);
        @(negedge clock);
        check_output("clr_done one cycle", clr_done, 0);
    endtask

    initial begin
        int   busy;
        int   ready_hi;
        int   rsp_idx;
        logic rsp_h;
        logic done_seen;
        int   cnt_done;
        int   cnt_busy;

        bus.ins_valid = 1'b1;
        bus.ins_addr  = 12'h555;
        bus.qry_valid = 1'b1;
        bus.qry_addr  = 12'h555;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset ready", {bus.ins_ready, bus.qry_ready}, 0);
        check_output("reset ram drive", {ram_address_a, ram_address_b, ram_wren_a, ram_wren_b, ram_data_a, ram_data_b}, 0);
        check_output("reset status", {bus.rsp_valid, bus.rsp_hit, clr_busy, clr_done}, 0);
        check_output("reset hit_cnt", hit_cnt, 0);
        bus.ins_valid = 1'b0;
        bus.qry_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_output("release ins_ready", bus.ins_ready, 1);
        check_output("release qry_ready", bus.qry_ready, 1);

        $display("[TB] initial clear");
        start_clear(1'b0, 12'h000, 1'b0, 12'h000);
        wait_clear(busy, ready_hi, rsp_idx, rsp_h, done_seen);
        check_output("clear1 busy cycles", busy, 2048);
        check_output("clear1 ready during clear", ready_hi, 0);
        check_output("clear1 stray rsp", rsp_idx, 32'hFFFFFFFF);

        $display("[TB] main vector table");
        vecs.delete();
        add_vec(0, 12'h000, 1, 12'hFFF, 0, 0, 0);
        add_vec(1, 12'h123, 0, 12'h000, 0, 0, 0);
        add_vec(0, 12'h000, 1, 12'h123, 1, 0, 0);
        add_vec(0, 12'h000, 1, 12'h124, 0, 0, 0);
        add_vec(0, 12'h000, 0, 12'h000, 1, 1, 0);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 1);
        add_vec(1, 12'h0AA, 1, 12'h0AA, 0, 0, 1);
        add_vec(0, 12'h000, 0, 12'h000, 0, 0, 1);
        add_vec(0, 12'h000, 0, 12'h000, 1, 1, 1);
        add_vec(1, 12'h005, 0, 12'h000, 0, 0, 2);
        for (int k = 0; k < 16; k++)
            add_vec(0, 12'h000, 1, 12'(k + 1), (k >= 2), (k == 6), (k <= 6) ? 16'd2 : 16'd3);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 3);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 3);
        add_vec(0, 12'h000, 0, 12'h000, 0, 0, 3);
        run_vectors("main");

        $display("[TB] clear with insert and in-flight query");
        start_clear(1'b1, 12'h200, 1'b1, 12'h123);
        wait_clear(busy, ready_hi, rsp_idx, rsp_h, done_seen);
        check_output("clear2 busy cycles", busy, 2048);
        check_output("clear2 ready during clear", ready_hi, 0);
        check_output("clear2 in-flight rsp cycle", rsp_idx, 1);
        check_output("clear2 in-flight rsp hit", rsp_h, 1);
        vecs.delete();
        add_vec(0, 12'h000, 1, 12'h200, 0, 0, 4);
        add_vec(0, 12'h000, 1, 12'h123, 0, 0, 4);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 4);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 4);
        add_vec(0, 12'h000, 0, 12'h000, 0, 0, 4);
        run_vectors("postclr");

        $display("[TB] reset during clear");
        start_clear(1'b0, 12'h000, 1'b0, 12'h000);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check_output("abort pre busy", clr_busy, 1);
        check_output("abort pre addr_a", ram_address_a, 12'd1000);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("abort status", {bus.rsp_valid, bus.rsp_hit, clr_busy, clr_done}, 0);
        check_output("abort ram drive", {ram_address_a, ram_address_b, ram_wren_a, ram_wren_b, ram_data_a, ram_data_b}, 0);
        check_output("abort hit_cnt", hit_cnt, 0);
        check_output("abort ready", {bus.ins_ready, bus.qry_ready}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_output("abort release ready", {bus.ins_ready, bus.qry_ready}, 2'b11);
        cnt_done = 0;
        cnt_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (clr_done) cnt_done++;
            if (clr_busy) cnt_busy++;
        end
        check_output("abort no clr_done", cnt_done, 0);
        check_output("abort no busy", cnt_busy, 0);
        vecs.delete();
        add_vec(1, 12'h7FF, 0, 12'h000, 0, 0, 0);
        add_vec(0, 12'h000, 1, 12'h7FF, 0, 0, 0);
        add_vec(0, 12'h000, 1, 12'h000, 0, 0, 0);
        add_vec(0, 12'h000, 0, 12'h000, 1, 1, 0);
        add_vec(0, 12'h000, 0, 12'h000, 1, 0, 1);
        add_vec(0, 12'h000, 0, 12'h000, 0, 0, 1);
        run_vectors("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
